pc_sequencer: RTL and testbench

// Parametrised program counter for the fetch stage. Generates word-aligned instruction

---
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: word-aligned address generation with stall, redirect
// and a wrap-or-trap policy for addresses outside instruction memory.
module pc_sequencer #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(32'h0100_0000),
  parameter int unsigned     IMEM_BYTES = 2048,
  parameter int unsigned     OOB_MODE   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            imm,
  input  logic [XLEN-1:0] imm_addr,
  input  logic            fault_clr,
  output logic [XLEN-1:0] instr_addr,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            wrap_evt,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam logic [XLEN-1:0] LAST_ADDR = RESET_ADDR + XLEN'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fault_addr_q;
  logic            wrap_q;
  logic            fault_q;

  logic [XLEN-1:0] cand_d;
  logic            oob_d;
  logic            advance_d;

  always_comb begin
    cand_d    = imm ? (imm_addr & ~XLEN'(3)) : pc_q + XLEN'(4);
    oob_d     = (cand_d < RESET_ADDR) || (cand_d > LAST_ADDR);
    advance_d = imm || !stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_ADDR;
      fault_addr_q <= '0;
      wrap_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (advance_d) begin
            if (!oob_d) begin
              pc_q <= cand_d;
            end else begin
              fault_addr_q <= cand_d;
              if (OOB_MODE == 0) begin
                pc_q   <= RESET_ADDR;
                wrap_q <= 1'b1;
              end else begin
                fault_q <= 1'b1;
                state_q <= FAULT;
              end
            end
          end
        end
        FAULT: begin
          if (fault_clr) begin
            fault_q <= 1'b0;
            pc_q    <= RESET_ADDR;
            state_q <= BOOT;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  // fetch_valid follows this cycle's stall, so it is derived rather than registered
  assign fetch_valid = (state_q == RUN) && !stall;
  assign instr_addr  = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign wrap_evt    = wrap_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: one instance per out-of-bounds policy, shared stimulus,
// expected per-cycle results queued as stimulus is applied and compared after each clock.
module tb_pc_sequencer;

  localparam logic [31:0] RA = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        imm = 1'b0;
  logic        fault_clr = 1'b0;
  logic [31:0] imm_addr = '0;

  logic [31:0] a0, p0, fa0, a1, p1, fa1;
  logic        fv0, w0, f0, fv1, w1, f1;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        fv;
    logic        wrap;
    logic        flt;
    logic [31:0] faddr;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(.XLEN(32), .RESET_ADDR(32'h0100_0000), .IMEM_BYTES(2048), .OOB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .imm(imm), .imm_addr(imm_addr), .fault_clr(fault_clr),
    .instr_addr(a0), .pc_plus4(p0), .fetch_valid(fv0), .wrap_evt(w0), .fault(f0), .fault_addr(fa0)
  );

  pc_sequencer #(.XLEN(32), .RESET_ADDR(32'h0100_0000), .IMEM_BYTES(2048), .OOB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .imm(imm), .imm_addr(imm_addr), .fault_clr(fault_clr),
    .instr_addr(a1), .pc_plus4(p1), .fetch_valid(fv1), .wrap_evt(w1), .fault(f1), .fault_addr(fa1)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [31:0] addr, logic fv, logic wrap, logic flt, logic [31:0] faddr);
    exp_t e;
    e.addr = addr; e.fv = fv; e.wrap = wrap; e.flt = flt; e.faddr = faddr;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; imm = 1'b0; fault_clr = 1'b0; imm_addr = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; imm = 1'b0; fault_clr = 1'b0; imm_addr = '0;
    #1;
    total++; if (a0 !== RA || a1 !== RA) $display("FAIL reset_addr: got %h/%h want %h", a0, a1, RA); else passed++;
    total++; if ({fv0, w0, f0, fv1, w1, f1} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {fv0, w0, f0, fv1, w1, f1}); else passed++;
    total++; if (fa0 !== 32'h0 || fa1 !== 32'h0) $display("FAIL reset_faddr: got %h/%h want 0", fa0, fa1); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (fv0 !== 1'b0) $display("FAIL boot_valid: got %b want 0", fv0); else passed++;
    sb.push_back(mk(RA, 1'b1, 1'b0, 1'b0, 32'h0));
    sb.push_back(mk(RA + 32'd4, 1'b1, 1'b0, 1'b0, 32'h0));
    sb.push_back(mk(RA + 32'd8, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (a0 !== e.addr || fv0 !== e.fv)
        $display("FAIL run_seq[%0d]: got addr %h valid %b want %h %b", i, a0, fv0, e.addr, e.fv);
      else passed++;
    end
    total++; if (p0 !== RA + 32'd12) $display("FAIL pc_plus4: got %h want %h", p0, RA + 32'd12); else passed++;
  endtask

  task automatic test_stall;
    exp_t e;
    apply_reset();
    repeat (5) tick();
    total++; if (a0 !== RA + 32'h10) $display("FAIL stall_start: got %h want %h", a0, RA + 32'h10); else passed++;
    stall = 1'b1;
    #1;
    total++; if (fv0 !== 1'b0) $display("FAIL stall_valid: got %b want 0", fv0); else passed++;
    for (int i = 0; i < 3; i++) sb.push_back(mk(RA + 32'h10, 1'b0, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (a0 !== e.addr || fv0 !== e.fv)
        $display("FAIL stall_hold[%0d]: got addr %h valid %b want %h %b", i, a0, fv0, e.addr, e.fv);
      else passed++;
    end
    stall = 1'b0;
    sb.push_back(mk(RA + 32'h14, 1'b1, 1'b0, 1'b0, 32'h0));
    tick();
    e = sb.pop_front();
    total++;
    if (a0 !== e.addr || fv0 !== e.fv) $display("FAIL stall_release: got addr %h valid %b want %h %b", a0, fv0, e.addr, e.fv);
    else passed++;
  endtask

  task automatic test_redirect;
    exp_t e;
    stall = 1'b1; imm = 1'b1; imm_addr = 32'h0100_0103;
    sb.push_back(mk(32'h0100_0100, 1'b0, 1'b0, 1'b0, 32'h0));
    tick();
    e = sb.pop_front();
    total++; if (a0 !== e.addr) $display("FAIL redirect_over_stall: got %h want %h", a0, e.addr); else passed++;
    stall = 1'b0; imm = 1'b0;
    #1;
    total++; if (p0 !== 32'h0100_0104) $display("FAIL redirect_plus4: got %h want 01000104", p0); else passed++;
    sb.push_back(mk(32'h0100_0104, 1'b1, 1'b0, 1'b0, 32'h0));
    tick();
    e = sb.pop_front();
    total++; if (a0 !== e.addr || fv0 !== e.fv) $display("FAIL redirect_next: got %h %b want %h %b", a0, fv0, e.addr, e.fv); else passed++;
  endtask

  task automatic test_wrap;
    exp_t e;
    imm = 1'b1; imm_addr = 32'h0100_07FC;
    sb.push_back(mk(32'h0100_07FC, 1'b1, 1'b0, 1'b0, 32'h0));
    sb.push_back(mk(RA, 1'b1, 1'b1, 1'b0, 32'h0100_0800));
    sb.push_back(mk(RA + 32'd4, 1'b1, 1'b0, 1'b0, 32'h0100_0800));
    for (int i = 0; i < 3; i++) begin
      tick();
      imm = 1'b0;
      e = sb.pop_front();
      total++;
      if (a0 !== e.addr || w0 !== e.wrap || fa0 !== e.faddr || f0 !== 1'b0)
        $display("FAIL wrap[%0d]: got addr %h wrap %b faddr %h fault %b want %h %b %h 0",
                 i, a0, w0, fa0, f0, e.addr, e.wrap, e.faddr);
      else passed++;
    end
  endtask

  task automatic test_fault;
    exp_t e;
    apply_reset();
    fault_clr = 1'b1;
    sb.push_back(mk(RA, 1'b1, 1'b0, 1'b0, 32'h0));
    sb.push_back(mk(RA + 32'd4, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (a1 !== e.addr || fv1 !== e.fv || f1 !== e.flt)
        $display("FAIL clr_outside_fault[%0d]: got %h %b %b want %h %b %b", i, a1, fv1, f1, e.addr, e.fv, e.flt);
      else passed++;
    end
    fault_clr = 1'b0;
    repeat (7) tick();
    total++; if (a1 !== RA + 32'h20) $display("FAIL fault_start: got %h want %h", a1, RA + 32'h20); else passed++;
    imm = 1'b1; imm_addr = 32'h00FF_FFFC;
    sb.push_back(mk(RA + 32'h20, 1'b0, 1'b0, 1'b1, 32'h00FF_FFFC));
    sb.push_back(mk(RA + 32'h20, 1'b0, 1'b0, 1'b1, 32'h00FF_FFFC));
    sb.push_back(mk(RA, 1'b0, 1'b0, 1'b0, 32'h00FF_FFFC));
    sb.push_back(mk(RA, 1'b1, 1'b0, 1'b0, 32'h00FF_FFFC));
    sb.push_back(mk(RA + 32'd4, 1'b1, 1'b0, 1'b0, 32'h00FF_FFFC));
    for (int i = 0; i < 5; i++) begin
      tick();
      case (i)
        0: imm_addr = 32'h0100_0100;
        1: begin imm = 1'b0; fault_clr = 1'b1; end
        default: fault_clr = 1'b0;
      endcase
      #1;
      e = sb.pop_front();
      total++;
      if (a1 !== e.addr || fv1 !== e.fv || f1 !== e.flt || fa1 !== e.faddr)
        $display("FAIL fault_seq[%0d]: got addr %h valid %b fault %b faddr %h want %h %b %b %h",
                 i, a1, fv1, f1, fa1, e.addr, e.fv, e.flt, e.faddr);
      else passed++;
    end
  endtask

  task automatic test_async_reset;
    imm = 1'b1; imm_addr = 32'h0100_0800;
    tick();
    imm = 1'b0; stall = 1'b1;
    total++; if (f1 !== 1'b1 || fa1 !== 32'h0100_0800 || a1 !== RA + 32'd4)
      $display("FAIL edge_oob: got fault %b faddr %h addr %h want 1 01000800 %h", f1, fa1, a1, RA + 32'd4);
    else passed++;
    total++; if (w0 !== 1'b1 || a0 !== RA) $display("FAIL edge_wrap: got wrap %b addr %h want 1 %h", w0, a0, RA); else passed++;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (a0 !== RA || a1 !== RA) $display("FAIL async_addr: got %h/%h want %h", a0, a1, RA); else passed++;
    total++; if ({fv0, w0, f0, fv1, w1, f1} !== 6'b0) $display("FAIL async_flags: got %b want 000000", {fv0, w0, f0, fv1, w1, f1}); else passed++;
    total++; if (fa0 !== 32'h0 || fa1 !== 32'h0) $display("FAIL async_faddr: got %h/%h want 0", fa0, fa1); else passed++;
    stall = 1'b0;
    tick();
    total++; if (a1 !== RA || fv1 !== 1'b0 || f1 !== 1'b0) $display("FAIL reset_held: got %h %b %b want %h 0 0", a1, fv1, f1, RA); else passed++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (a1 !== RA || fv1 !== 1'b1) $display("FAIL post_reset_run: got %h %b want %h 1", a1, fv1, RA); else passed++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
